javk_biu: RTL and testbench

- Parametrised bus interface unit for the next-generation JAVK core.
- Replaces ad-hoc fetch/addressing logic with one owner of the external address/data bus.
- Contains a DEPTH-entry instruction prefetch queue, a core data-access port (load/store), wait-state support and flush-on-branch.
- Sits between the core's control/datapath and the shared memory bus.

---
 rtl/javk_biu_pkg.sv | 17 +
 rtl/javk_fifo.sv | 66 ++++++
 rtl/javk_biu.sv | 144 ++++++++++++++
 tb/tb_javk_biu.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/javk_biu_pkg.sv
// Shared types and constants for the JAVK bus interface unit.
package javk_biu_pkg;

    typedef enum logic [1:0] {
        BiuIdle   = 2'd0,
        BiuFetch  = 2'd1,
        BiuDread  = 2'd2,
        BiuDwrite = 2'd3
    } biu_state_e;

    localparam logic RwRead  = 1'b0;
    localparam logic RwWrite = 1'b1;

    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefAddrW = 16;

endpackage

// File: rtl/javk_fifo.sv
// Prefetch queue: DEPTH-entry ring buffer with flush; flush overrides push and pop.
module javk_fifo
    import javk_biu_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic [DATA_W-1:0]        rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              pop_ok, push_ok, wr_en;

    always_comb begin
        pop_ok   = pop_i && (count_q != '0);
        push_ok  = push_i && ((count_q != CntW'(DEPTH)) || pop_ok);
        wr_en    = push_ok && !flush_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/javk_biu.sv
// JAVK bus interface unit: single owner of the memory bus, arbitrating instruction
// prefetch against core load/store, with wait states and flush-on-branch.
module javk_biu
    import javk_biu_pkg::*;
#(
    parameter int unsigned       DATA_W   = DefDataW,
    parameter int unsigned       ADDR_W   = DefAddrW,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [DATA_W-1:0] databus,
    output logic [ADDR_W-1:0] addrbus,
    output logic              rw,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_pop,
    output logic [ADDR_W-1:0] pc_out,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_new,
    input  logic              dreq,
    input  logic              dwe,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dwdata,
    output logic [DATA_W-1:0] drdata,
    output logic              dack
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    biu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, fetch_pc_q, fetch_pc_d, pc_q, pc_d, base_pc;
    logic [DATA_W-1:0] wdata_q, wdata_d, drdata_q, drdata_d;
    logic              rw_q, rw_d, dack_q, dack_d, discard_q, discard_d;

    logic              complete, fetch_done, data_done, issue, push, pop;
    logic [CntW-1:0]   count, count_after;
    logic              fifo_empty;

    javk_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (pc_load),
        .wdata_i (databus),
        .rdata_o (instr),
        .count_o (count),
        .empty_o (fifo_empty)
    );

    always_comb begin
        complete   = (state_q != BiuIdle) && mem_ready;
        fetch_done = complete && (state_q == BiuFetch);
        data_done  = complete && ((state_q == BiuDread) || (state_q == BiuDwrite));
        issue      = (state_q == BiuIdle) || complete;
        push       = fetch_done && !discard_q && !pc_load;
        pop        = instr_pop && !pc_load && !fifo_empty;
        // Occupancy after this edge; the only fetch in flight is the one completing now.
        count_after = pc_load ? '0 : (count + CntW'(push) - CntW'(pop));
        base_pc     = pc_load ? pc_new : fetch_pc_q;

        state_d    = state_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        wdata_d    = wdata_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        drdata_d   = drdata_q;
        dack_d     = 1'b0;
        discard_d  = discard_q;

        if (data_done) begin
            dack_d = 1'b1;
            if (state_q == BiuDread) drdata_d = databus;
        end

        if (fetch_done) discard_d = 1'b0;

        if (pc_load) begin
            pc_d       = pc_new;
            fetch_pc_d = pc_new;
            // Memory cannot abort a fetch; tag it so its data is dropped on arrival.
            if ((state_q == BiuFetch) && !mem_ready) discard_d = 1'b1;
        end else if (pop) begin
            pc_d = pc_q + ADDR_W'(1);
        end

        if (issue) begin
            if (dreq && !dack_q && !data_done) begin
                state_d = dwe ? BiuDwrite : BiuDread;
                addr_d  = daddr;
                rw_d    = dwe ? RwWrite : RwRead;
                wdata_d = dwdata;
            end else if (count_after < CntW'(DEPTH)) begin
                state_d    = BiuFetch;
                addr_d     = base_pc;
                rw_d       = RwRead;
                fetch_pc_d = base_pc + ADDR_W'(1);
            end else begin
                state_d = BiuIdle;
                rw_d    = RwRead;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BiuIdle;
            addr_q     <= '0;
            rw_q       <= RwRead;
            wdata_q    <= '0;
            fetch_pc_q <= RESET_PC;
            pc_q       <= RESET_PC;
            drdata_q   <= '0;
            dack_q     <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            wdata_q    <= wdata_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            drdata_q   <= drdata_d;
            dack_q     <= dack_d;
            discard_q  <= discard_d;
        end
    end

    assign databus     = rw_q ? wdata_q : {DATA_W{1'bz}};
    assign addrbus     = addr_q;
    assign rw          = rw_q;
    assign pc_out      = pc_q;
    assign instr_valid = !fifo_empty;
    assign drdata      = drdata_q;
    assign dack        = dack_q;

endmodule

// File: tb/tb_javk_biu.sv
// Self-checking bench for javk_biu: directed scenarios plus a randomized run checked
// against an address-stream / memory reference model.
module tb_javk_biu;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    wire  [DW-1:0] databus;
    logic [AW-1:0] addrbus;
    logic          rw;
    logic          mem_ready;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic          instr_pop;
    logic [AW-1:0] pc_out;
    logic          pc_load;
    logic [AW-1:0] pc_new;
    logic          dreq;
    logic          dwe;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dwdata;
    logic [DW-1:0] drdata;
    logic          dack;

    logic [DW-1:0] mem     [65536];
    logic [DW-1:0] ref_mem [65536];

    int n_cmp = 0;
    int n_bad = 0;

    javk_biu #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .DEPTH    (4),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .databus     (databus),
        .addrbus     (addrbus),
        .rw          (rw),
        .mem_ready   (mem_ready),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_pop   (instr_pop),
        .pc_out      (pc_out),
        .pc_load     (pc_load),
        .pc_new      (pc_new),
        .dreq        (dreq),
        .dwe         (dwe),
        .daddr       (daddr),
        .dwdata      (dwdata),
        .drdata      (drdata),
        .dack        (dack)
    );

    always #5 clk = ~clk;

    // Memory drives the bus on reads only, and never during reset.
    assign databus = (!rw && !rst) ? mem[addrbus] : {DW{1'bz}};

    always @(posedge clk) begin
        if (!rst && rw && mem_ready) mem[addrbus] <= databus;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        logic [DW-1:0] t;
        t = a[7:0] + 8'd1;
        return t * 8'd17;
    endfunction

    task automatic init_mem();
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = pat(AW'(i));
            ref_mem[i] = pat(AW'(i));
        end
    endtask

    task automatic idle_inputs();
        instr_pop = 1'b0;
        pc_load   = 1'b0;
        pc_new    = '0;
        dreq      = 1'b0;
        dwe       = 1'b0;
        daddr     = '0;
        dwdata    = '0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        mem_ready = 1'b1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [AW-1:0] exp_pc;
    logic          pend, pend_we, was_valid, drv_pop, drv_pcl;
    logic [AW-1:0] pend_addr, drv_pcnew;
    logic [DW-1:0] pend_data;
    int            pend_age, dack_seen;

    initial begin
        init_mem();

        // Reset values and cold fetch
        idle_inputs();
        mem_ready = 1'b1;
        rst = 1'b1;
        step();
        check_eq("rst_addr", 32'(addrbus), 0);
        check_eq("rst_rw", 32'(rw), 0);
        check_eq("rst_valid", 32'(instr_valid), 0);
        check_eq("rst_pc", 32'(pc_out), 0);
        check_eq("rst_dack", 32'(dack), 0);
        check_eq("rst_drdata", 32'(drdata), 0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("cold_addr", 32'(addrbus), k);
            check_eq("cold_rw", 32'(rw), 0);
            check_eq("cold_valid", 32'(instr_valid), (k == 0) ? 0 : 1);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("cold_stop", 32'(addrbus), 3);
        end
        check_eq("cold_instr", 32'(instr), 32'h11);
        check_eq("cold_pc", 32'(pc_out), 0);

        // Two wait states per access
        do_reset();
        for (int k = 0; k < 12; k++) begin
            mem_ready = (k % 3 == 0);
            step();
            check_eq("ws_addr", 32'(addrbus), k / 3);
            check_eq("ws_rw", 32'(rw), 0);
        end
        mem_ready = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            check_eq("ws_instr", 32'(instr), 32'(pat(AW'(i))));
            check_eq("ws_pc", 32'(pc_out), i);
            instr_pop = 1'b1;
            step();
        end
        instr_pop = 1'b0;

        // Store then load take priority over fetch
        do_reset();
        step();
        step();
        dreq = 1'b1; dwe = 1'b1; daddr = 16'h8000; dwdata = 8'hA5;
        step();
        check_eq("st_rw", 32'(rw), 1);
        check_eq("st_addr", 32'(addrbus), 32'h8000);
        check_eq("st_data", 32'(databus), 32'hA5);
        check_eq("st_dack_early", 32'(dack), 0);
        step();
        check_eq("st_dack", 32'(dack), 1);
        dreq = 1'b0;
        step();
        check_eq("st_dack_pulse", 32'(dack), 0);
        check_eq("st_mem", 32'(mem[16'h8000]), 32'hA5);
        dreq = 1'b1; dwe = 1'b0; daddr = 16'h8000;
        dack_seen = 0;
        for (int i = 0; i < 20 && dack_seen == 0; i++) begin
            step();
            if (dack) dack_seen = 1;
        end
        check_eq("ld_dack", 32'(dack_seen), 1);
        check_eq("ld_data", 32'(drdata), 32'hA5);
        dreq = 1'b0;
        step();
        instr_pop = 1'b1;
        step();
        instr_pop = 1'b0;
        for (int i = 0; i < 10 && !(addrbus == 16'd4 && !rw); i++) step();
        check_eq("ld_resume", 32'(addrbus), 4);

        // Branch flush while a fetch is held in wait states
        do_reset();
        for (int i = 0; i < 4; i++) step();
        check_eq("fl_inflight", 32'(addrbus), 3);
        mem_ready = 1'b0;
        step();
        step();
        pc_load = 1'b1; pc_new = 16'h1234;
        step();
        pc_load = 1'b0;
        check_eq("fl_valid", 32'(instr_valid), 0);
        check_eq("fl_pc", 32'(pc_out), 32'h1234);
        check_eq("fl_hold", 32'(addrbus), 3);
        mem_ready = 1'b1;
        step();
        check_eq("fl_addr", 32'(addrbus), 32'h1234);
        check_eq("fl_discard", 32'(instr_valid), 0);
        step();
        check_eq("fl_instr", 32'(instr), 32'(pat(16'h1234)));
        check_eq("fl_pc2", 32'(pc_out), 32'h1234);

        // Address wrap, then sustained pops
        for (int i = 0; i < 6; i++) step();
        pc_load = 1'b1; pc_new = 16'hFFFE;
        step();
        pc_load = 1'b0;
        check_eq("wr_a0", 32'(addrbus), 32'hFFFE);
        step();
        check_eq("wr_a1", 32'(addrbus), 32'hFFFF);
        step();
        check_eq("wr_a2", 32'(addrbus), 0);
        for (int i = 0; i < 4; i++) step();
        exp_pc = 16'hFFFE;
        instr_pop = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_pc = exp_pc + 16'd1;
            check_eq("pop_pc", 32'(pc_out), 32'(exp_pc));
            check_eq("pop_valid", 32'(instr_valid), 1);
            check_eq("pop_instr", 32'(instr), 32'(pat(exp_pc)));
        end
        instr_pop = 1'b0;

        // Asynchronous reset in the middle of a stalled write
        do_reset();
        mem_ready = 1'b0;
        dreq = 1'b1; dwe = 1'b1; daddr = 16'h8010; dwdata = 8'h5A;
        step();
        check_eq("ar_rw", 32'(rw), 1);
        step();
        check_eq("ar_rw_held", 32'(rw), 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_rw_rst", 32'(rw), 0);
        check_eq("ar_bus_rel", 32'(databus === 8'h5A), 0);
        check_eq("ar_dack", 32'(dack), 0);
        check_eq("ar_pc", 32'(pc_out), 0);
        check_eq("ar_addr", 32'(addrbus), 0);
        idle_inputs();
        mem_ready = 1'b1;
        step();
        rst = 1'b0;
        step();
        check_eq("ar_no_write", 32'(mem[16'h8010]), 32'(pat(16'h8010)));
        check_eq("ar_no_dack", 32'(dack), 0);

        // Randomized run against the reference model
        init_mem();
        do_reset();
        exp_pc    = '0;
        pend      = 1'b0;
        pend_we   = 1'b0;
        pend_addr = '0;
        pend_data = '0;
        pend_age  = 0;
        was_valid = 1'b0;
        drv_pop   = 1'b0;
        drv_pcl   = 1'b0;
        drv_pcnew = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (drv_pcl) exp_pc = drv_pcnew;
            else if (drv_pop && was_valid) exp_pc = exp_pc + 16'd1;
            check_eq("rnd_pc", 32'(pc_out), 32'(exp_pc));
            if (instr_valid) check_eq("rnd_instr", 32'(instr), 32'(ref_mem[exp_pc]));
            if (rw) begin
                check_eq("rnd_wr_req", {30'd0, pend, pend_we}, 32'd3);
                check_eq("rnd_wr_addr", 32'(addrbus), 32'(pend_addr));
                check_eq("rnd_wr_data", 32'(databus), 32'(pend_data));
            end
            if (dack) begin
                check_eq("rnd_dack_req", 32'(pend), 1);
                if (pend && pend_we) ref_mem[pend_addr] = pend_data;
                else if (pend) check_eq("rnd_ld", 32'(drdata), 32'(ref_mem[pend_addr]));
                pend = 1'b0;
                dreq = 1'b0;
            end else if (pend) begin
                pend_age++;
                if (pend_age > 100) begin
                    check_eq("rnd_dack_timeout", 32'(dack), 1);
                    pend = 1'b0;
                    dreq = 1'b0;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                pend      = 1'b1;
                pend_age  = 0;
                pend_we   = 1'($urandom_range(0, 1));
                pend_addr = 16'h8000 + AW'($urandom_range(0, 15));
                pend_data = DW'($urandom_range(0, 255));
                dreq      = 1'b1;
                dwe       = pend_we;
                daddr     = pend_addr;
                dwdata    = pend_data;
            end
            was_valid = instr_valid;
            mem_ready = ($urandom_range(0, 3) != 0);
            drv_pop   = 1'($urandom_range(0, 1));
            drv_pcl   = ($urandom_range(0, 49) == 0);
            drv_pcnew = AW'($urandom_range(0, 16'h6FFF));
            instr_pop = drv_pop;
            pc_load   = drv_pcl;
            pc_new    = drv_pcnew;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
